// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the control bundle that travels
// down the pixel pipeline alongside the renderer's colour.
package vga_pkg;

  localparam int VGA_H_ACTIVE   = 640;
  localparam int VGA_H_FP       = 16;
  localparam int VGA_H_SYNC     = 96;
  localparam int VGA_H_BP       = 48;
  localparam int VGA_V_ACTIVE   = 480;
  localparam int VGA_V_FP       = 10;
  localparam int VGA_V_SYNC     = 2;
  localparam int VGA_V_BP       = 33;
  localparam int VGA_PIPE_DELAY = 2;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W = 10;
  localparam int RGB_W = 12;

  // All-zero means "blank, no sync", which is also the flush value.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_ctl_t;

endpackage

// File: rtl/vga_delay_line.sv
// Synchronously clearable shift register; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync generation and blanking; sync/blank are delayed to
// line up with a renderer that returns colour PIPE_DELAY clocks after pixel_x/y.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int PIPE_DELAY = VGA_PIPE_DELAY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  input  logic [RGB_W-1:0] color_in,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb_out,
  output logic             frame_start,
  output logic [15:0]      frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  vga_ctl_t         raw_ctl;
  vga_ctl_t         dly_ctl;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = h_wrap && (v_cnt == V_LAST);

  // Disabling parks the raster at the origin so re-enable always starts a clean frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_count <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (v_wrap) begin
        v_cnt       <= '0;
        frame_count <= frame_count + 16'd1;
      end else if (h_wrap) begin
        v_cnt <= v_cnt + 1'b1;
      end
    end
  end

  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign frame_start = en && !rst && (h_cnt == '0) && (v_cnt == '0);

  always_comb begin
    raw_ctl        = '0;
    raw_ctl.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    raw_ctl.hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    raw_ctl.vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  vga_delay_line #(
    .WIDTH ($bits(vga_ctl_t)),
    .DEPTH (PIPE_DELAY)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .clr  (!en),
    .din  (raw_ctl),
    .dout (dly_ctl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      rgb_out <= '0;
    end else if (!en) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      rgb_out <= '0;
    end else begin
      hsync   <= ~dly_ctl.hs;
      vsync   <= ~dly_ctl.vs;
      rgb_out <= dly_ctl.active ? color_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a scaled-down raster (30x15) so whole frames
// stay short; expectations are derived from the bench's own geometry.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [13:0] IDLE = {1'b1, 1'b1, 12'h000};

  typedef struct {
    int          x;
    int          y;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] color_in;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb_out;
  logic        frame_start;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .color_in    (color_in),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb_out     (rgb_out),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Renderer stand-in: colour = {2'b0, pixel_x}, returned two clocks later.
  logic [11:0] c1, c2;
  always @(posedge clk) begin
    c1 <= {2'b00, pixel_x};
    c2 <= c1;
  end
  assign color_in = c2;

  function automatic logic [13:0] exp_out(input int x, input int y);
    logic        hs_n, vs_n;
    logic [11:0] rgb;
    hs_n = !(x >= HA + HF && x < HA + HF + HS);
    vs_n = !(y >= VA + VF && y < VA + VF + VS);
    rgb  = (x < HA && y < VA) ? 12'(x) : 12'h000;
    return {hs_n, vs_n, rgb};
  endfunction

  // Reference raster position, frame count and enable history.
  int          m_x, m_y;
  logic [15:0] m_fc;
  logic [2:0]  en_hist;
  logic        sb_on = 1'b0;
  logic [13:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_x     <= 0;
      m_y     <= 0;
      m_fc    <= '0;
      en_hist <= 3'b000;
    end else begin
      en_hist <= {en_hist[1:0], en};
      if (!en) begin
        m_x <= 0;
        m_y <= 0;
      end else if (m_x == HT - 1) begin
        m_x <= 0;
        if (m_y == VT - 1) begin
          m_y  <= 0;
          m_fc <= m_fc + 16'd1;
        end else begin
          m_y <= m_y + 1;
        end
      end else begin
        m_x <= m_x + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [13:0] e;
    if (rst) begin
      exp_q.delete();
    end else if (sb_on) begin
      check("pos", {pixel_x, pixel_y}, {10'(m_x), 10'(m_y)});
      check("frame_start", frame_start, en && m_x == 0 && m_y == 0);
      check("frame_count", frame_count, m_fc);
      exp_q.push_back(exp_out(m_x, m_y));
      if (exp_q.size() > PD + 1) begin
        e = exp_q.pop_front();
        if (en_hist != 3'b111) e = IDLE;
        check("out", {hsync, vsync, rgb_out}, e);
      end
    end
  end

  task automatic wait_pix(input int x, input int y, output bit found);
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      @(negedge clk);
      if (pixel_x == 10'(x) && pixel_y == 10'(y)) found = 1'b1;
    end
    check($sformatf("reach_%0d_%0d", x, y), found, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pos"}, {pixel_x, pixel_y}, 0);
    check({tag, "_out"}, {hsync, vsync, rgb_out}, IDLE);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_fc"}, frame_count, 0);
  endtask

  vec_t vecs[16];

  initial begin
    bit ok;
    int hs_low, vs_low, lat;
    logic [15:0] fc0;

    vecs[0]  = '{0,  0,  1'b1, 1'b1, 12'h000};
    vecs[1]  = '{1,  0,  1'b1, 1'b1, 12'h001};
    vecs[2]  = '{15, 0,  1'b1, 1'b1, 12'h00F};
    vecs[3]  = '{16, 0,  1'b1, 1'b1, 12'h000};
    vecs[4]  = '{19, 0,  1'b1, 1'b1, 12'h000};
    vecs[5]  = '{20, 0,  1'b0, 1'b1, 12'h000};
    vecs[6]  = '{25, 0,  1'b0, 1'b1, 12'h000};
    vecs[7]  = '{26, 0,  1'b1, 1'b1, 12'h000};
    vecs[8]  = '{29, 0,  1'b1, 1'b1, 12'h000};
    vecs[9]  = '{5,  7,  1'b1, 1'b1, 12'h005};
    vecs[10] = '{5,  8,  1'b1, 1'b1, 12'h000};
    vecs[11] = '{21, 9,  1'b0, 1'b1, 12'h000};
    vecs[12] = '{3,  10, 1'b1, 1'b0, 12'h000};
    vecs[13] = '{22, 11, 1'b0, 1'b0, 12'h000};
    vecs[14] = '{3,  12, 1'b1, 1'b1, 12'h000};
    vecs[15] = '{29, 14, 1'b1, 1'b1, 12'h000};

    // Reset with en already high: frame_start must still stay low.
    rst = 1'b1;
    en  = 1'b0;
    #12 en = 1'b1;
    @(negedge clk);
    check_reset_state("reset");

    @(posedge clk); #1;
    rst   = 1'b0;
    sb_on = 1'b1;

    // Two full frames: total sync-low time and frame count.
    hs_low = 0;
    vs_low = 0;
    for (int c = 0; c < 2 * FT + 3; c++) begin
      @(negedge clk);
      if (c == 0) check("fs_first", frame_start, 1);
      if (c >= 3) begin
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
      end
      if (c == 2 * FT - 1) check("fc_before", frame_count, 1);
      if (c == 2 * FT) check("fc_two", frame_count, 2);
    end
    check("hs_low_total", hs_low, 2 * VT * HS);
    check("vs_low_total", vs_low, 2 * VS * HT);

    for (int i = 0; i < 16; i++) begin
      wait_pix(vecs[i].x, vecs[i].y, ok);
      if (ok) begin
        repeat (PD + 1) @(negedge clk);
        check($sformatf("vec%0d", i), {hsync, vsync, rgb_out},
              {vecs[i].hs, vecs[i].vs, vecs[i].rgb});
      end
    end

    // Latency of first visible colour and of the hsync falling edge.
    wait_pix(1, 0, ok);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (rgb_out != 12'h000) lat = i;
    end
    check("rgb_latency", lat, PD + 1);
    wait_pix(HA + HF, 0, ok);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (!hsync) lat = i;
    end
    check("hsync_latency", lat, PD + 1);

    // Line and frame wrap.
    wait_pix(HT - 1, 3, ok);
    @(negedge clk);
    check("hwrap_pos", {pixel_x, pixel_y}, {10'd0, 10'd4});
    wait_pix(HT - 1, VT - 1, ok);
    fc0 = m_fc;
    @(negedge clk);
    check("vwrap_pos", {pixel_x, pixel_y}, 0);
    check("vwrap_fs", frame_start, 1);
    check("vwrap_fc", frame_count, fc0 + 16'd1);
    @(negedge clk);
    check("fs_one_cycle", frame_start, 0);

    // Enable dropped mid-frame for 10 clocks.
    wait_pix(10, 5, ok);
    fc0 = m_fc;
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    check("fs_en_low", frame_start, 0);
    @(negedge clk);
    check("idle_out", {hsync, vsync, rgb_out}, IDLE);
    check("idle_pos", {pixel_x, pixel_y}, 0);
    repeat (9) @(posedge clk);
    #1;
    check("idle_fc", frame_count, fc0);
    en = 1'b1;
    @(negedge clk);
    check("restart_fs", frame_start, 1);
    check("restart_pos", {pixel_x, pixel_y}, 0);
    check("restart_fc", frame_count, fc0);

    // Random enable bursts.
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 60)) @(posedge clk);
      #1;
    end
    en = 1'b1;

    // Asynchronous reset between clock edges, mid-line.
    wait_pix(7, 2, ok);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2 * HT) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
